// File: rtl/wireframe_pkg.sv
// wireframe_pkg: shared colour type, default palette and edge-list helpers for wireframe_render_pipe
package wireframe_pkg;

    typedef logic [11:0] rgb444_t;

    localparam int LATENCY = 3;
    localparam rgb444_t VTX_COLOR = 12'h000;

    // Vertices are black; edges cycle through six saturated colours.
    function automatic rgb444_t pal_default(input int k, input int nv);
        if (k < nv) return VTX_COLOR;
        case ((k - nv) % 6)
            0:       return 12'hF00;
            1:       return 12'h0F0;
            2:       return 12'h00F;
            3:       return 12'hFF0;
            4:       return 12'hF0F;
            default: return 12'h0FF;
        endcase
    endfunction

    // Edge e occupies bits [6e+5:6e] = {b,a}; b selects the upper endpoint.
    function automatic int edge_end(input logic [71:0] list, input int e, input logic b);
        return int'(list[6*e + (b ? 3 : 0) +: 3]);
    endfunction

endpackage

// File: rtl/wireframe_render_pipe_edge_hit_unit.sv
// edge_hit_unit: S1-S2 of one edge test (direction/offset vectors, cross product, tolerance, bounding box)
module edge_hit_unit #(
    parameter int CW    = 11,
    parameter int THICK = 1
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic signed [CW:0]      i_x,
    input  logic signed [CW:0]      i_y,
    input  logic signed [CW-1:0]    i_xa,
    input  logic signed [CW-1:0]    i_ya,
    input  logic signed [CW-1:0]    i_xb,
    input  logic signed [CW-1:0]    i_yb,
    output logic signed [2*CW+2:0]  o_cross,
    output logic signed [2*CW+2:0]  o_lim,
    output logic                    o_bbox,
    output logic                    o_degen
);

    localparam logic signed [CW+2:0] ZERO = '0;
    localparam logic signed [CW+2:0] T    = (CW+3)'(THICK);

    logic signed [CW:0]     r_ex, r_ey, r_px, r_py;
    logic signed [CW:0]     w_aex, w_aey;
    logic signed [2*CW+2:0] w_exl, w_eyl, w_pxl, w_pyl, w_mx;
    logic signed [CW+2:0]   w_exs, w_eys, w_pxs, w_pys;
    logic signed [CW+2:0]   w_xlo, w_xhi, w_ylo, w_yhi;

    assign w_aex = r_ex[CW] ? -r_ex : r_ex;
    assign w_aey = r_ey[CW] ? -r_ey : r_ey;
    assign w_mx  = (2*CW+3)'(w_aex > w_aey ? w_aex : w_aey);
    assign w_exl = (2*CW+3)'(r_ex);
    assign w_eyl = (2*CW+3)'(r_ey);
    assign w_pxl = (2*CW+3)'(r_px);
    assign w_pyl = (2*CW+3)'(r_py);

    // Bounding box is tested relative to endpoint a: px must lie within [min(0,ex)-T, max(0,ex)+T].
    assign w_exs = (CW+3)'(r_ex);
    assign w_eys = (CW+3)'(r_ey);
    assign w_pxs = (CW+3)'(r_px);
    assign w_pys = (CW+3)'(r_py);
    assign w_xlo = (w_exs[CW+2] ? w_exs : ZERO) - T;
    assign w_xhi = (w_exs[CW+2] ? ZERO : w_exs) + T;
    assign w_ylo = (w_eys[CW+2] ? w_eys : ZERO) - T;
    assign w_yhi = (w_eys[CW+2] ? ZERO : w_eys) + T;

    // S1: edge direction and pixel offset from endpoint a
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_ex <= '0;
            r_ey <= '0;
            r_px <= '0;
            r_py <= '0;
        end else begin
            r_ex <= (CW+1)'(i_xb) - (CW+1)'(i_xa);
            r_ey <= (CW+1)'(i_yb) - (CW+1)'(i_ya);
            r_px <= i_x - (CW+1)'(i_xa);
            r_py <= i_y - (CW+1)'(i_ya);
        end
    end

    // S2: cross product against thickness-scaled tolerance, bbox and degenerate flags
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            o_cross <= '0;
            o_lim   <= '0;
            o_bbox  <= 1'b0;
            o_degen <= 1'b0;
        end else begin
            o_cross <= w_pxl * w_eyl - w_pyl * w_exl;
            o_lim   <= w_mx * (2*CW+3)'(THICK);
            o_bbox  <= w_pxs >= w_xlo && w_pxs <= w_xhi && w_pys >= w_ylo && w_pys <= w_yhi;
            o_degen <= r_ex == '0 && r_ey == '0;
        end
    end

endmodule

// File: rtl/wireframe_render_pipe.sv
// wireframe_render_pipe: double-buffered vertex set, 3-stage point/edge hit test and colour arbiter.
// Optional PALETTE_WR_EN makes the palette writable registers instead of constants.
module wireframe_render_pipe
    import wireframe_pkg::*;
#(
    parameter int                    NUM_VTX   = 4,
    parameter int                    NUM_EDGES = 6,
    parameter logic [6*NUM_EDGES-1:0] EDGE_LIST = {3'd2,3'd3, 3'd1,3'd3, 3'd1,3'd2, 3'd0,3'd3, 3'd0,3'd2, 3'd0,3'd1},
    parameter int                    CW        = 11,
    parameter int                    PT_R      = 2,
    parameter int                    THICK     = 1,
    parameter rgb444_t               BG_COLOR  = 12'h49C
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [9:0]           h_cnt,
    input  logic [9:0]           v_cnt,
    input  logic                 de_in,
    input  logic                 frame_start,
    input  logic                 vtx_valid,
    output logic                 vtx_ready,
    input  logic [2:0]           vtx_idx,
    input  logic signed [CW-1:0] vtx_x,
    input  logic signed [CW-1:0] vtx_y,
    input  logic                 vtx_last,
    input  logic                 pal_we,
    input  logic [4:0]           pal_addr,
    input  rgb444_t              pal_data,
    output rgb444_t              rgb_out,
    output logic                 de_out,
    output logic                 swap_pulse
);

    localparam int NP = NUM_VTX + NUM_EDGES;
    localparam logic signed [CW:0] R = (CW+1)'(PT_R);

    logic signed [CW-1:0]   r_sx [NUM_VTX];
    logic signed [CW-1:0]   r_sy [NUM_VTX];
    logic signed [CW-1:0]   r_ax [NUM_VTX];
    logic signed [CW-1:0]   r_ay [NUM_VTX];
    logic                   r_pending;
    logic                   w_wr, w_swap;
    logic signed [CW:0]     w_x, w_y;
    logic signed [CW:0]     r_dx [NUM_VTX];
    logic signed [CW:0]     r_dy [NUM_VTX];
    logic [NUM_VTX-1:0]     r_phit;
    logic [LATENCY-2:0]     r_de;
    logic signed [2*CW+2:0] w_cross [NUM_EDGES];
    logic signed [2*CW+2:0] w_lim [NUM_EDGES];
    logic [NUM_EDGES-1:0]   w_bbox, w_degen, w_ehit;
    rgb444_t                w_pal [NP];
    rgb444_t                w_color;

    assign vtx_ready = !r_pending;
    assign w_wr      = vtx_valid && !r_pending;
    assign w_swap    = frame_start && r_pending;
    assign w_x       = (CW+1)'(h_cnt);
    assign w_y       = (CW+1)'(v_cnt);

    // Shadow loading, pending flag and frame-start swap into the active set
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_pending  <= 1'b0;
            swap_pulse <= 1'b0;
            for (int i = 0; i < NUM_VTX; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
                r_ax[i] <= '0;
                r_ay[i] <= '0;
            end
        end else begin
            swap_pulse <= w_swap;
            if (w_swap)
                r_pending <= 1'b0;
            else if (w_wr && vtx_last)
                r_pending <= 1'b1;
            for (int i = 0; i < NUM_VTX; i++) begin
                if (w_wr && int'(vtx_idx) == i) begin
                    r_sx[i] <= vtx_x;
                    r_sy[i] <= vtx_y;
                end
                if (w_swap) begin
                    r_ax[i] <= r_sx[i];
                    r_ay[i] <= r_sy[i];
                end
            end
        end
    end

    // S1/S2 point tests and the de delay line
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_de   <= '0;
            r_phit <= '0;
            for (int i = 0; i < NUM_VTX; i++) begin
                r_dx[i] <= '0;
                r_dy[i] <= '0;
            end
        end else begin
            r_de <= {r_de[LATENCY-3:0], de_in};
            for (int i = 0; i < NUM_VTX; i++) begin
                r_dx[i]   <= w_x - (CW+1)'(r_ax[i]);
                r_dy[i]   <= w_y - (CW+1)'(r_ay[i]);
                r_phit[i] <= r_dx[i] >= -R && r_dx[i] <= R && r_dy[i] >= -R && r_dy[i] <= R;
            end
        end
    end

    for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
        localparam int A = edge_end(72'(EDGE_LIST), e, 1'b0);
        localparam int B = edge_end(72'(EDGE_LIST), e, 1'b1);
        edge_hit_unit #(.CW(CW), .THICK(THICK)) u_edge (
            .pclk    (pclk),
            .rst     (rst),
            .i_x     (w_x),
            .i_y     (w_y),
            .i_xa    (r_ax[A]),
            .i_ya    (r_ay[A]),
            .i_xb    (r_ax[B]),
            .i_yb    (r_ay[B]),
            .o_cross (w_cross[e]),
            .o_lim   (w_lim[e]),
            .o_bbox  (w_bbox[e]),
            .o_degen (w_degen[e])
        );
        assign w_ehit[e] = !w_degen[e] && w_bbox[e] &&
                           ((w_cross[e][2*CW+2] ? -w_cross[e] : w_cross[e]) <= w_lim[e]);
    end

`ifdef PALETTE_WR_EN
    rgb444_t r_pal [NP];

    // Writable palette, reset to the default colours; out-of-range addresses match no entry
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NP; k++)
                r_pal[k] <= pal_default(k, NUM_VTX);
        end else begin
            for (int k = 0; k < NP; k++)
                if (pal_we && int'(pal_addr) == k)
                    r_pal[k] <= pal_data;
        end
    end

    assign w_pal = r_pal;
`else
    logic w_unused_pal;
    assign w_unused_pal = ^{pal_we, pal_addr, pal_data};

    for (genvar k = 0; k < NP; k++) begin : g_pal
        assign w_pal[k] = pal_default(k, NUM_VTX);
    end
`endif

    // S3 arbiter: any point beats any edge, lower index beats higher
    always_comb begin
        w_color = BG_COLOR;
        for (int i = NUM_EDGES - 1; i >= 0; i--)
            if (w_ehit[i]) w_color = w_pal[NUM_VTX + i];
        for (int i = NUM_VTX - 1; i >= 0; i--)
            if (r_phit[i]) w_color = w_pal[i];
    end

    // S3 output register; blanked outside active video
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rgb_out <= '0;
            de_out  <= 1'b0;
        end else begin
            rgb_out <= r_de[LATENCY-2] ? w_color : '0;
            de_out  <= r_de[LATENCY-2];
        end
    end

endmodule

// File: tb/tb_wireframe_render_pipe.sv
// tb_wireframe_render_pipe: directed checks of reset, load/swap, hit priority and pixel timing
module tb_wireframe_render_pipe;

    logic               pclk = 1'b0;
    logic               rst = 1'b1;
    logic [9:0]         h_cnt = '0;
    logic [9:0]         v_cnt = '0;
    logic               de_in = 1'b0;
    logic               frame_start = 1'b0;
    logic               vtx_valid = 1'b0;
    logic               vtx_ready;
    logic [2:0]         vtx_idx = '0;
    logic signed [10:0] vtx_x = '0;
    logic signed [10:0] vtx_y = '0;
    logic               vtx_last = 1'b0;
    logic               pal_we = 1'b0;
    logic [4:0]         pal_addr = '0;
    logic [11:0]        pal_data = '0;
    logic [11:0]        rgb_out;
    logic               de_out;
    logic               swap_pulse;

    int n_chk = 0;
    int n_fail = 0;

    wireframe_render_pipe dut (
        .pclk        (pclk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .de_in       (de_in),
        .frame_start (frame_start),
        .vtx_valid   (vtx_valid),
        .vtx_ready   (vtx_ready),
        .vtx_idx     (vtx_idx),
        .vtx_x       (vtx_x),
        .vtx_y       (vtx_y),
        .vtx_last    (vtx_last),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
        .rgb_out     (rgb_out),
        .de_out      (de_out),
        .swap_pulse  (swap_pulse)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic de, input logic [11:0] exp);
        h_cnt = 10'(x);
        v_cnt = 10'(y);
        de_in = de;
        repeat (3) @(posedge pclk);
        #1;
        chk(tag, rgb_out, exp);
        chk({tag, "_de"}, {11'b0, de_out}, {11'b0, de});
    endtask

    task automatic wr(input int idx, input int x, input int y, input logic last, input logic fs);
        vtx_valid   = 1'b1;
        vtx_idx     = 3'(idx);
        vtx_x       = 11'(x);
        vtx_y       = 11'(y);
        vtx_last    = last;
        frame_start = fs;
        @(posedge pclk);
        #1;
        vtx_valid   = 1'b0;
        vtx_last    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fsp(input string tag, input logic exp);
        frame_start = 1'b1;
        @(posedge pclk);
        #1;
        frame_start = 1'b0;
        chk(tag, {11'b0, swap_pulse}, {11'b0, exp});
        if (exp) begin
            @(posedge pclk);
            #1;
            chk({tag, "_drop"}, {11'b0, swap_pulse}, 12'h0);
        end
    endtask

    initial begin
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_rgb", rgb_out, 12'h0);
        chk("rst_de", {11'b0, de_out}, 12'h0);
        chk("rst_ready", {11'b0, vtx_ready}, 12'h1);
        chk("rst_swap", {11'b0, swap_pulse}, 12'h0);
        rst = 1'b0;

        pix("bg_before_load", 100, 100, 1'b1, 12'h49C);
        wr(0, 7, 7, 1'b1, 1'b0);
        chk("ready_pending", {11'b0, vtx_ready}, 12'h0);
        @(posedge pclk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_rgb", rgb_out, 12'h0);
        chk("midrst_de", {11'b0, de_out}, 12'h0);
        chk("midrst_ready", {11'b0, vtx_ready}, 12'h1);
        @(posedge pclk);
        #1;
        rst = 1'b0;

        pix("zero_v0", 0, 0, 1'b1, 12'h000);
        pix("zero_bg", 100, 100, 1'b1, 12'h49C);
        fsp("no_swap_idle", 1'b0);

        wr(0, 100, 100, 1'b0, 1'b0);
        chk("ready_mid_load", {11'b0, vtx_ready}, 12'h1);
        wr(1, 300, 100, 1'b0, 1'b0);
        wr(2, 100, 300, 1'b0, 1'b0);
        wr(3, 300, 300, 1'b1, 1'b0);
        chk("ready_after_last", {11'b0, vtx_ready}, 12'h0);
        pix("no_tear_pre_swap", 200, 100, 1'b1, 12'h49C);
        fsp("swap1", 1'b1);
        chk("ready_after_swap", {11'b0, vtx_ready}, 12'h1);

        pix("edge0", 200, 100, 1'b1, 12'hF00);
        pix("edge0_thick", 200, 101, 1'b1, 12'hF00);
        pix("edge0_outside", 200, 102, 1'b1, 12'h49C);
        pix("point_prio", 101, 99, 1'b1, 12'h000);
        pix("edge1", 100, 200, 1'b1, 12'h0F0);
        pix("edge2_over_3", 200, 200, 1'b1, 12'h00F);
        pix("edge4", 300, 200, 1'b1, 12'hF0F);
        pix("edge5", 200, 300, 1'b1, 12'h0FF);
        pix("point_rim", 302, 302, 1'b1, 12'h000);
        pix("point_past_rim", 303, 300, 1'b1, 12'h49C);
        pix("blank", 200, 100, 1'b0, 12'h000);

`ifdef PALETTE_WR_EN
        pal_we   = 1'b1;
        pal_addr = 5'd4;
        pal_data = 12'h0AA;
        @(posedge pclk);
        #1;
        pal_addr = 5'd31;
        pal_data = 12'hFFF;
        @(posedge pclk);
        #1;
        pal_we = 1'b0;
        pix("pal_edge0", 200, 100, 1'b1, 12'h0AA);
        pix("pal_edge1_kept", 100, 200, 1'b1, 12'h0F0);
        pix("pal_bg_kept", 200, 102, 1'b1, 12'h49C);
`endif

        wr(0, 50, 50, 1'b0, 1'b0);
        wr(1, 50, 50, 1'b0, 1'b0);
        wr(2, 400, 50, 1'b0, 1'b0);
        wr(5, 60, 50, 1'b0, 1'b0);
        wr(3, 400, 400, 1'b1, 1'b1);
        chk("same_cycle_no_swap", {11'b0, swap_pulse}, 12'h0);
        chk("same_cycle_pending", {11'b0, vtx_ready}, 12'h0);
`ifdef PALETTE_WR_EN
        pix("old_set_kept", 200, 100, 1'b1, 12'h0AA);
`else
        pix("old_set_kept", 200, 100, 1'b1, 12'hF00);
`endif
        fsp("swap2", 1'b1);

        pix("degen_point", 50, 50, 1'b1, 12'h000);
        pix("degen_rim", 52, 50, 1'b1, 12'h000);
        pix("degen_edge1", 53, 50, 1'b1, 12'h0F0);
        pix("idx5_ignored", 60, 50, 1'b1, 12'h0F0);
        pix("new_set_bg", 200, 100, 1'b1, 12'h49C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
